// File: rtl/net_to_cpu_cache_pkg.sv
// Block geometry and shared types for the net-to-CPU-cache read path (package lu_new).
package lu_new;

  localparam int LANES        = 4;
  localparam int BSIZE        = 8;
  localparam int MAX_BDIMBITS = 8;
  localparam int CACHE_AWIDTH = 8;
  localparam int CACHE_DWIDTH = LANES * 32;

  // Word address of the final beat in a block; counters advance by LANES per beat.
  localparam logic [CACHE_AWIDTH-1:0] LAST      = CACHE_AWIDTH'(BSIZE * BSIZE - LANES);
  localparam logic [CACHE_AWIDTH-1:0] LANES_INC = CACHE_AWIDTH'(LANES);

  typedef struct packed {
    logic top;
    logic cur;
    logic left;
  } t_buftrio;

  typedef struct packed {
    t_buftrio bufs;
    logic     page;
  } t_cache_which;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2
  } t_n2c_state;

  function automatic logic is_last(input logic [CACHE_AWIDTH-1:0] addr);
    return (addr == LAST);
  endfunction

endpackage

// File: rtl/net_to_cpu_cache_if.sv
// Message, network and cache-write signals of net_to_cpu_cache; slave is the block side.
interface net_to_cpu_cache_if;
  import lu_new::*;

  logic                    i_msg_rdreq;
  logic [MAX_BDIMBITS-1:0] i_msg_rdreq_blkx;
  logic [MAX_BDIMBITS-1:0] i_msg_rdreq_blky;
  t_buftrio                i_msg_rdreq_whichbufs;
  logic                    i_msg_rdreq_whichpage;
  logic                    o_msg_rddone;

  logic [MAX_BDIMBITS-1:0] o_net_rdreq_x;
  logic [MAX_BDIMBITS-1:0] o_net_rdreq_y;
  logic                    o_net_rdreq_valid;
  logic                    i_net_rdreq_ready;

  logic [CACHE_DWIDTH-1:0] i_net_rdresp_data;
  logic                    i_net_rdresp_valid;
  logic                    o_net_rdresp_ready;
  logic                    i_net_rdresp_sop;
  logic                    i_net_rdresp_eop;

  logic [CACHE_AWIDTH-1:0] o_cache_wrreq_addr;
  logic [CACHE_DWIDTH-1:0] o_cache_wrreq_data;
  logic                    o_cache_wrreq_valid;
  logic                    i_cache_wrreq_ready;
  t_cache_which            o_cache_wrreq_which;

  logic                    o_err;

  modport slave (
    input  i_msg_rdreq, i_msg_rdreq_blkx, i_msg_rdreq_blky, i_msg_rdreq_whichbufs,
           i_msg_rdreq_whichpage, i_net_rdreq_ready, i_net_rdresp_data, i_net_rdresp_valid,
           i_net_rdresp_sop, i_net_rdresp_eop, i_cache_wrreq_ready,
    output o_msg_rddone, o_net_rdreq_x, o_net_rdreq_y, o_net_rdreq_valid, o_net_rdresp_ready,
           o_cache_wrreq_addr, o_cache_wrreq_data, o_cache_wrreq_valid, o_cache_wrreq_which,
           o_err
  );

  modport master (
    output i_msg_rdreq, i_msg_rdreq_blkx, i_msg_rdreq_blky, i_msg_rdreq_whichbufs,
           i_msg_rdreq_whichpage, i_net_rdreq_ready, i_net_rdresp_data, i_net_rdresp_valid,
           i_net_rdresp_sop, i_net_rdresp_eop, i_cache_wrreq_ready,
    input  o_msg_rddone, o_net_rdreq_x, o_net_rdreq_y, o_net_rdreq_valid, o_net_rdresp_ready,
           o_cache_wrreq_addr, o_cache_wrreq_data, o_cache_wrreq_valid, o_cache_wrreq_which,
           o_err
  );
endinterface

// File: rtl/net_to_cpu_cache_pipe_interlock.sv
// One-entry valid/ready pipeline stage; REGISTERED=0 degenerates to a wire.
module pipe_interlock #(
  parameter int REGISTERED = 1,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             want_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  if (REGISTERED != 0) begin : g_reg
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Accept while empty or while the held word drains this cycle.
    assign want_o  = !full_q || ready_i;
    assign valid_o = full_q;
    assign data_o  = data_q;

    // Next-state of the holding register.
    always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (valid_i && want_o) begin
        full_d = 1'b1;
        data_d = data_i;
      end else if (ready_i) begin
        full_d = 1'b0;
      end else begin
        full_d = full_q;
      end
    end

    // Holding register state.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else begin
        full_q <= full_d;
        data_q <= data_d;
      end
    end
  end else begin : g_comb
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ reset_n;
    assign want_o  = ready_i;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end

endmodule

// File: rtl/net_to_cpu_cache.sv
// Fetches one block from the network on RDREQ and writes it into the CPU cache buffers.
// Optional protocol checker: define NET_TO_CACHE_CHECK_EN.
import lu_new::*;

module net_to_cpu_cache #(
  parameter int REGISTERED = 1
) (
  input logic               clk,
  input logic               reset_n,
  net_to_cpu_cache_if.slave bus
);

  t_n2c_state              state_q, state_d;
  logic [MAX_BDIMBITS-1:0] blkx_q, blkx_d, blky_q, blky_d;
  t_buftrio                bufs_q, bufs_d;
  logic                    page_q, page_d;
  logic [CACHE_AWIDTH-1:0] rx_cnt_q, rx_cnt_d, wr_addr_q, wr_addr_d;
  logic                    rx_done_q, rx_done_d;

  logic                    in_recv_s, il_valid_in_s, il_want_s, il_valid_out_s;
  logic                    beat_acc_s, wr_acc_s;
  logic [CACHE_DWIDTH-1:0] il_data_out_s;

  // Beats only enter the stage while receiving and before the final beat has been taken.
  assign in_recv_s     = (state_q == RECV);
  assign il_valid_in_s = bus.i_net_rdresp_valid && in_recv_s && !rx_done_q;
  assign beat_acc_s    = il_valid_in_s && il_want_s;
  assign wr_acc_s      = il_valid_out_s && bus.i_cache_wrreq_ready;

  pipe_interlock #(
    .REGISTERED (REGISTERED),
    .WIDTH      (CACHE_DWIDTH)
  ) u_ilock (
    .clk     (clk),
    .reset_n (reset_n),
    .data_i  (bus.i_net_rdresp_data),
    .valid_i (il_valid_in_s),
    .want_o  (il_want_s),
    .data_o  (il_data_out_s),
    .valid_o (il_valid_out_s),
    .ready_i (bus.i_cache_wrreq_ready)
  );

  assign bus.o_net_rdreq_valid   = (state_q == REQ);
  assign bus.o_net_rdreq_x       = blkx_q;
  assign bus.o_net_rdreq_y       = blky_q;
  assign bus.o_net_rdresp_ready  = in_recv_s && il_want_s && !rx_done_q;
  assign bus.o_cache_wrreq_valid = il_valid_out_s;
  assign bus.o_cache_wrreq_data  = il_data_out_s;
  assign bus.o_cache_wrreq_addr  = wr_addr_q;
  assign bus.o_cache_wrreq_which = '{bufs: bufs_q, page: page_q};
  assign bus.o_msg_rddone        = wr_acc_s && is_last(wr_addr_q);

  // Next-state: request capture, net handshake and beat/write accounting.
  always_comb begin
    state_d   = state_q;
    blkx_d    = blkx_q;
    blky_d    = blky_q;
    bufs_d    = bufs_q;
    page_d    = page_q;
    rx_cnt_d  = rx_cnt_q;
    wr_addr_d = wr_addr_q;
    rx_done_d = rx_done_q;
    case (state_q)
      IDLE: begin
        if (bus.i_msg_rdreq) begin
          blkx_d    = bus.i_msg_rdreq_blkx;
          blky_d    = bus.i_msg_rdreq_blky;
          bufs_d    = bus.i_msg_rdreq_whichbufs;
          page_d    = bus.i_msg_rdreq_whichpage;
          rx_cnt_d  = '0;
          wr_addr_d = '0;
          rx_done_d = 1'b0;
          state_d   = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.i_net_rdreq_ready) begin
          state_d = RECV;
        end else begin
          state_d = REQ;
        end
      end
      RECV: begin
        if (beat_acc_s) begin
          rx_cnt_d  = rx_cnt_q + LANES_INC;
          rx_done_d = rx_done_q || is_last(rx_cnt_q);
        end else begin
          rx_cnt_d  = rx_cnt_q;
        end
        if (wr_acc_s) begin
          wr_addr_d = wr_addr_q + LANES_INC;
          state_d   = is_last(wr_addr_q) ? IDLE : RECV;
        end else begin
          state_d   = RECV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      blkx_q    <= '0;
      blky_q    <= '0;
      bufs_q    <= '0;
      page_q    <= 1'b0;
      rx_cnt_q  <= '0;
      wr_addr_q <= '0;
      rx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      blkx_q    <= blkx_d;
      blky_q    <= blky_d;
      bufs_q    <= bufs_d;
      page_q    <= page_d;
      rx_cnt_q  <= rx_cnt_d;
      wr_addr_q <= wr_addr_d;
      rx_done_q <= rx_done_d;
    end
  end

`ifdef NET_TO_CACHE_CHECK_EN
  logic err_q, err_d, proto_err_s;

  // Framing must agree with the beat count: sop only first, eop only on LAST.
  always_comb begin
    proto_err_s = 1'b0;
    if (beat_acc_s) begin
      proto_err_s = ((rx_cnt_q == '0) != bus.i_net_rdresp_sop) ||
                    (is_last(rx_cnt_q) != bus.i_net_rdresp_eop);
    end else begin
      proto_err_s = 1'b0;
    end
    if ((state_q == IDLE) && bus.i_net_rdresp_valid) begin
      proto_err_s = 1'b1;
    end else begin
      proto_err_s = proto_err_s;
    end
    err_d = err_q || proto_err_s;
  end

  // Sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.o_err = err_q;

`ifndef SYNTHESIS
  // Report each protocol violation as it occurs.
  always @(posedge clk) begin
    if (reset_n && proto_err_s) begin
      $error("net_to_cpu_cache: rdresp framing error, rx_cnt=%0d", rx_cnt_q);
    end
  end
`endif
`else
  logic unused_framing_s;
  assign unused_framing_s = bus.i_net_rdresp_sop ^ bus.i_net_rdresp_eop;
  assign bus.o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_net_to_cpu_cache.sv
// Scoreboard bench for net_to_cpu_cache: stimulus pushes expected cache writes, a monitor pops them.
module tb_net_to_cpu_cache;
  import lu_new::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  net_to_cpu_cache_if ifc();

  net_to_cpu_cache #(.REGISTERED(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  typedef struct {
    logic [CACHE_AWIDTH-1:0] addr;
    logic [CACHE_DWIDTH-1:0] data;
    logic [3:0]              which;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rddone_cnt = 0;
  int   wr_cnt = 0;
  bit   lat_arm = 1'b0;
  int   acc_cyc = -1;
  int   wr_cyc = -1;
  int   last_wr_cyc = -1;
  bit   tog_en = 1'b0;
  logic [3:0] cur_which = 4'b0000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CACHE_DWIDTH-1:0] mk(input int pkt, input int k);
    logic [CACHE_DWIDTH-1:0] d;
    for (int j = 0; j < LANES; j++) begin
      d[j*32 +: 32] = 32'hA000_0000 | 32'(pkt << 16) | 32'(k * LANES + j);
    end
    return d;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cache ready: toggles each cycle when enabled, otherwise held high.
  initial begin
    ifc.i_cache_wrreq_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog_en) ifc.i_cache_wrreq_ready = ~ifc.i_cache_wrreq_ready;
      else        ifc.i_cache_wrreq_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted cache write.
  logic                    stall_q = 1'b0;
  logic [CACHE_AWIDTH-1:0] st_addr;
  logic [CACHE_DWIDTH-1:0] st_data;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("stall_valid_held", ifc.o_cache_wrreq_valid, 1'b1);
          chk("stall_addr_held", ifc.o_cache_wrreq_addr, st_addr);
          chk("stall_data_held", ifc.o_cache_wrreq_data, st_data);
        end
        stall_q = ifc.o_cache_wrreq_valid && !ifc.i_cache_wrreq_ready;
        st_addr = ifc.o_cache_wrreq_addr;
        st_data = ifc.o_cache_wrreq_data;
        if (stall_q) chk("full_ilock_blocks_net", ifc.o_net_rdresp_ready, 1'b0);
        if (lat_arm && acc_cyc < 0 && ifc.i_net_rdresp_valid && ifc.o_net_rdresp_ready)
          acc_cyc = cyc;
        if (ifc.o_cache_wrreq_valid && ifc.i_cache_wrreq_ready) begin
          wr_cnt++;
          if (lat_arm) begin
            if (wr_cyc < 0) wr_cyc = cyc;
            last_wr_cyc = cyc;
          end
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: addr %0d with empty scoreboard", ifc.o_cache_wrreq_addr);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", ifc.o_cache_wrreq_addr, e.addr);
            chk("wr_data", ifc.o_cache_wrreq_data, e.data);
            chk("wr_which", ifc.o_cache_wrreq_which, e.which);
            chk("rddone_with_write", ifc.o_msg_rddone, (e.addr == LAST));
          end
        end else if (ifc.o_msg_rddone) begin
          checks++;
          failures++;
          $display("FAIL rddone_without_write: got 1 required 0");
        end
        if (ifc.o_msg_rddone) rddone_cnt++;
      end
    end
  end

  task automatic do_req(input int x, input int y, input logic [2:0] bufs, input logic page,
                        input int hold);
    ifc.i_msg_rdreq           = 1'b1;
    ifc.i_msg_rdreq_blkx      = 8'(x);
    ifc.i_msg_rdreq_blky      = 8'(y);
    ifc.i_msg_rdreq_whichbufs = bufs;
    ifc.i_msg_rdreq_whichpage = page;
    cur_which                 = {bufs, page};
    @(posedge clk);
    #1;
    ifc.i_msg_rdreq = 1'b0;
    for (int h = 0; h < hold; h++) begin
      ifc.i_net_rdresp_valid = 1'b1;
      @(negedge clk);
      chk("req_valid_held", ifc.o_net_rdreq_valid, 1'b1);
      chk("req_x_held", ifc.o_net_rdreq_x, 8'(x));
      chk("req_y_held", ifc.o_net_rdreq_y, 8'(y));
      chk("no_beat_in_req", ifc.o_net_rdresp_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    ifc.i_net_rdresp_valid = 1'b0;
    ifc.i_net_rdreq_ready  = 1'b1;
    @(negedge clk);
    chk("req_valid", ifc.o_net_rdreq_valid, 1'b1);
    @(posedge clk);
    #1;
    ifc.i_net_rdreq_ready = 1'b0;
    @(negedge clk);
    chk("req_dropped_after_accept", ifc.o_net_rdreq_valid, 1'b0);
    chk("recv_ready", ifc.o_net_rdresp_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int pkt, input int k0, input int k1, input int eop_beat);
    exp_t e;
    int   t;
    logic got;
    for (int k = k0; k < k1; k++) begin
      e.addr  = 8'(k * LANES);
      e.data  = mk(pkt, k);
      e.which = cur_which;
      exp_q.push_back(e);
      ifc.i_net_rdresp_valid = 1'b1;
      ifc.i_net_rdresp_data  = e.data;
      ifc.i_net_rdresp_sop   = (k == 0);
      ifc.i_net_rdresp_eop   = (k == eop_beat);
      t = 0;
      do begin
        @(negedge clk);
        got = ifc.o_net_rdresp_ready;
        @(posedge clk);
        #1;
        t++;
      end while (!got && t < 200);
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL beat_accept_timeout: beat %0d not accepted in 200 cycles", k);
        break;
      end
    end
    ifc.i_net_rdresp_valid = 1'b0;
    ifc.i_net_rdresp_sop   = 1'b0;
    ifc.i_net_rdresp_eop   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rd0, w0;
    logic exp_err;
    ifc.i_msg_rdreq           = 1'b0;
    ifc.i_msg_rdreq_blkx      = '0;
    ifc.i_msg_rdreq_blky      = '0;
    ifc.i_msg_rdreq_whichbufs = '0;
    ifc.i_msg_rdreq_whichpage = 1'b0;
    ifc.i_net_rdreq_ready     = 1'b0;
    ifc.i_net_rdresp_data     = '0;
    ifc.i_net_rdresp_valid    = 1'b0;
    ifc.i_net_rdresp_sop      = 1'b0;
    ifc.i_net_rdresp_eop      = 1'b0;

    #12;
    chk("rst_rdreq_valid", ifc.o_net_rdreq_valid, 1'b0);
    chk("rst_rdresp_ready", ifc.o_net_rdresp_ready, 1'b0);
    chk("rst_cache_valid", ifc.o_cache_wrreq_valid, 1'b0);
    chk("rst_rddone", ifc.o_msg_rddone, 1'b0);
    chk("rst_err", ifc.o_err, 1'b0);
    chk("rst_addr", ifc.o_cache_wrreq_addr, 8'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Request handshake with 4 stalled cycles, then a full-rate packet.
    do_req(3, 5, 3'b010, 1'b1, 4);
    lat_arm = 1'b1;
    rd0 = rddone_cnt;
    w0  = wr_cnt;
    send(1, 0, 16, 15);
    drain();
    lat_arm = 1'b0;
    chk("first_write_latency", wr_cyc - acc_cyc, 1);
    chk("writes_back_to_back", last_wr_cyc - wr_cyc, 15);
    chk("p1_rddone_once", rddone_cnt - rd0, 1);
    chk("p1_write_count", wr_cnt - w0, 16);
    @(negedge clk);
    chk("idle_no_rdreq", ifc.o_net_rdreq_valid, 1'b0);
    chk("idle_no_rdresp_ready", ifc.o_net_rdresp_ready, 1'b0);
    @(posedge clk);
    #1;

    // Cache ready toggling every cycle.
    tog_en = 1'b1;
    rd0 = rddone_cnt;
    w0  = wr_cnt;
    do_req(7, 2, 3'b100, 1'b0, 0);
    send(2, 0, 16, 15);
    drain();
    tog_en = 1'b0;
    chk("p2_rddone_once", rddone_cnt - rd0, 1);
    chk("p2_write_count", wr_cnt - w0, 16);
    @(posedge clk);
    #1;

    // Asynchronous reset after beat 7.
    rd0 = rddone_cnt;
    do_req(1, 1, 3'b001, 1'b1, 0);
    send(3, 0, 8, 15);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_cache_valid", ifc.o_cache_wrreq_valid, 1'b0);
    chk("arst_rdresp_ready", ifc.o_net_rdresp_ready, 1'b0);
    chk("arst_rdreq_valid", ifc.o_net_rdreq_valid, 1'b0);
    chk("arst_rddone", ifc.o_msg_rddone, 1'b0);
    chk("arst_addr", ifc.o_cache_wrreq_addr, 8'd0);
    exp_q.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_rddone", rddone_cnt - rd0, 0);
    rd0 = rddone_cnt;
    w0  = wr_cnt;
    do_req(3, 5, 3'b010, 1'b1, 0);
    send(4, 0, 16, 15);
    drain();
    chk("p4_rddone_once", rddone_cnt - rd0, 1);
    chk("p4_write_count", wr_cnt - w0, 16);

    // A second RDREQ during RECV is ignored.
    rd0 = rddone_cnt;
    do_req(6, 4, 3'b010, 1'b0, 0);
    send(5, 0, 8, 15);
    ifc.i_msg_rdreq           = 1'b1;
    ifc.i_msg_rdreq_blkx      = 8'd9;
    ifc.i_msg_rdreq_blky      = 8'd9;
    ifc.i_msg_rdreq_whichbufs = 3'b100;
    ifc.i_msg_rdreq_whichpage = 1'b1;
    @(posedge clk);
    #1;
    ifc.i_msg_rdreq = 1'b0;
    @(negedge clk);
    chk("ignored_req_x", ifc.o_net_rdreq_x, 8'd6);
    chk("ignored_req_y", ifc.o_net_rdreq_y, 8'd4);
    chk("ignored_req_no_valid", ifc.o_net_rdreq_valid, 1'b0);
    @(posedge clk);
    #1;
    send(5, 8, 16, 15);
    drain();
    chk("p5_rddone_once", rddone_cnt - rd0, 1);
    @(negedge clk);
    chk("p5_idle_no_rdreq", ifc.o_net_rdreq_valid, 1'b0);
    @(posedge clk);
    #1;

    // Early eop on beat 10.
`ifdef NET_TO_CACHE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    w0 = wr_cnt;
    do_req(2, 2, 3'b010, 1'b1, 0);
    send(6, 0, 16, 10);
    drain();
    chk("early_eop_err", ifc.o_err, exp_err);
    chk("early_eop_write_count", wr_cnt - w0, 16);
    repeat (5) @(posedge clk);
    #1;
    chk("early_eop_err_sticky", ifc.o_err, exp_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
